ps2_char_receiver: RTL

Front-end keyboard stage directly upstream of the display controller.
- Samples a PS/2 keyboard line (ps2_clk/ps2_data) in the Pixelclock domain and deframes 11-bit PS/2 frames.
- Strips break (F0) and extended (E0) prefixes.
- Presents each new key press as an 8-bit make code on character, with a one-cycle check strobe, which the display controller consumes directly.

---
 rtl/ps2_char_receiver_pkg.sv | 29 ++
 rtl/ps2_char_receiver_if.sv | 33 +++
 rtl/ps2_char_receiver_clk_filter.sv | 53 +++++
 rtl/ps2_char_receiver.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ps2_char_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_char_receiver_pkg
// Purpose  : Shared constants, FSM encoding and parity helper for the PS/2
//            character receiver.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_char_receiver_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 25000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
    return ^{data_byte, parity_bit};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_char_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_char_receiver_if
// Purpose  : Keyboard line inputs and decoded character outputs of the
//            receiver, grouped for connection to the display controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_char_receiver_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] character;
  logic       check;
  logic       frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output character,
    output check,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  character,
    input  check,
    input  frame_err
  );

endinterface
`default_nettype wire

// File: rtl/ps2_char_receiver_clk_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_clk_filter
// Purpose  : Synchronises the raw PS/2 lines, debounces the clock with a
//            FILTER_LEN-deep history and emits a one-cycle fall event.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_clk_filter
  import ps2_char_receiver_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  wire logic Pixelclock,
  input  wire logic reset,
  input  wire logic i_ps2_clk,
  input  wire logic i_ps2_data,
  output logic      o_fall,
  output logic      o_data
);

  logic [1:0]            r_clk_sync;
  logic [1:0]            r_data_sync;
  logic [FILTER_LEN-1:0] r_hist;
  logic                  r_filt;
  logic                  r_fall;

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_hist      <= '1;
      r_filt      <= 1'b1;
      r_fall      <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_hist      <= {r_hist[FILTER_LEN-2:0], r_clk_sync[1]};
      r_fall      <= 1'b0;
      // The filtered level only moves on a unanimous history; mixed holds.
      if (r_hist == '0) begin
        r_filt <= 1'b0;
        r_fall <= r_filt;
      end else if (&r_hist) begin
        r_filt <= 1'b1;
      end
    end
  end

  assign o_fall = r_fall;
  assign o_data = r_data_sync[1];

endmodule
`default_nettype wire

// File: rtl/ps2_char_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_char_receiver
// Purpose  : Deframes PS/2 keyboard frames, strips F0/E0 prefixes and presents
//            each key press as a make code with a one-cycle check strobe.
//            Optional macro PS2_TIMEOUT_EN abandons stalled partial frames.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_char_receiver
  import ps2_char_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  wire logic           Pixelclock,
  input  wire logic           reset,
  ps2_char_receiver_if.master bus
);

  if (FILTER_LEN < 2 || FILTER_LEN > 16) begin : g_bad_filter_len
    $error("FILTER_LEN must be within 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic       w_fall;
  logic       w_data;
  logic       w_timeout;

  ps2_state_t r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_parity;
  logic       r_byte_valid;
  logic       r_frame_err;
  logic [7:0] r_character;
  logic       r_check;
  logic       r_break_pending;
  logic       r_ext_pending;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .Pixelclock (Pixelclock),
    .reset      (reset),
    .i_ps2_clk  (bus.ps2_clk),
    .i_ps2_data (bus.ps2_data),
    .o_fall     (w_fall),
    .o_data     (w_data)
  );

`ifdef PS2_TIMEOUT_EN
  localparam int               c_tmo_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT_CYCLES);

  logic [c_tmo_w-1:0] r_tmo_cnt;

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (w_fall || r_state == IDLE) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != c_tmo_max) begin
      r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
    end
  end

  assign w_timeout = (r_state != IDLE) && (r_tmo_cnt == c_tmo_max);
`else
  assign w_timeout = 1'b0;
`endif

  // Deframer: every transition is gated by a filtered falling edge.
  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_parity     <= 1'b0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        case (r_state)
          IDLE: begin
            if (!w_data) begin
              r_state   <= DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= PARITY;
            end
          end
          PARITY: begin
            r_parity <= w_data;
            r_state  <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (w_data && odd_parity_ok(r_shift, r_parity)) begin
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_timeout) begin
        r_state     <= IDLE;
        r_frame_err <= 1'b1;
      end
    end
  end

  // r_shift stays stable for a whole bit period after STOP, so the decoder
  // reads it directly one cycle later.
  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      r_character     <= 8'h00;
      r_check         <= 1'b0;
      r_break_pending <= 1'b0;
      r_ext_pending   <= 1'b0;
    end else begin
      r_check <= 1'b0;
      if (r_byte_valid) begin
        if (r_shift == PS2_BREAK) begin
          r_break_pending <= 1'b1;
        end else if (r_shift == PS2_EXT) begin
          r_ext_pending <= 1'b1;
        end else if (r_break_pending) begin
          r_break_pending <= 1'b0;
          r_ext_pending   <= 1'b0;
        end else begin
          r_character <= r_shift;
          r_check     <= 1'b1;
          if (r_ext_pending) begin
            r_ext_pending <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.character = r_character;
  assign bus.check     = r_check;
  assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire
